// File: rtl/vga_pkg.sv
// Shared VGA constants and the dot position record used by the overlay and its bench.
package vga_pkg;
    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int COLOR_W      = 12;
    localparam int POS_X_W      = 10;
    localparam int POS_Y_W      = 9;
    localparam int RESET_DOT_X  = 320;
    localparam int RESET_DOT_Y  = 240;

    typedef struct packed {
        logic [POS_X_W-1:0] x;
        logic [POS_Y_W-1:0] y;
    } dot_pos_t;
endpackage

// File: rtl/vga_dot_cmp.sv
// Combinational test: does pixel (px,py) fall inside the DOT_SIZE square anchored at (dot_x,dot_y)?
module vga_dot_cmp #(
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 9,
    parameter int DOT_SIZE = 1
) (
    input  logic [X_WIDTH-1:0] px,
    input  logic [Y_WIDTH-1:0] py,
    input  logic [X_WIDTH-1:0] dot_x,
    input  logic [Y_WIDTH-1:0] dot_y,
    output logic               in_dot
);
    import vga_pkg::*;

    localparam logic [X_WIDTH:0] SIZE_X = (X_WIDTH+1)'(DOT_SIZE);
    localparam logic [Y_WIDTH:0] SIZE_Y = (Y_WIDTH+1)'(DOT_SIZE);

    logic [X_WIDTH:0] x_end;
    logic [Y_WIDTH:0] y_end;

    // One extra bit on the far edge so a dot near the border never wraps to 0.
    always_comb begin
        x_end  = {1'b0, dot_x} + SIZE_X;
        y_end  = {1'b0, dot_y} + SIZE_Y;
        in_dot = (px >= dot_x) && ({1'b0, px} < x_end) &&
                 (py >= dot_y) && ({1'b0, py} < y_end);
    end
endmodule

// File: rtl/vga_dot_overlay.sv
// Dot sprite overlay for the VGA colour path; define DOT_DOUBLE_BUFFER_EN for
// shadow/active position tables swapped on the rising edge of screenEnd.
module vga_dot_overlay #(
    parameter int                 NUM_DOTS  = 20,
    parameter int                 X_WIDTH   = 10,
    parameter int                 Y_WIDTH   = 9,
    parameter int                 DOT_SIZE  = 1,
    parameter int                 COLOR_W   = 12,
    parameter logic [COLOR_W-1:0] DOT_COLOR = '0,
    parameter int                 RESET_X   = 320,
    parameter int                 RESET_Y   = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               screenEnd,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic [COLOR_W-1:0] bgColor,
    input  logic               dotWren,
    input  logic               is_Yloc,
    input  logic [31:0]        dotID,
    input  logic [31:0]        dotLoc,
    output logic               wr_ready,
    output logic               wr_err,
    output logic               frameTick,
    output logic               hit,
    output logic [COLOR_W-1:0] colorOut
);
    import vga_pkg::*;

    localparam logic [X_WIDTH-1:0] RST_X = X_WIDTH'(RESET_X);
    localparam logic [Y_WIDTH-1:0] RST_Y = Y_WIDTH'(RESET_Y);

    // Write handshake: a write is taken on any clk edge where dotWren && wr_ready;
    // the requester must hold dotWren and its payload until it sees wr_ready.
    logic [X_WIDTH-1:0] act_x [NUM_DOTS];
    logic [Y_WIDTH-1:0] act_y [NUM_DOTS];
    logic               screen_end_q;
    logic               swap;
    logic               id_ok;
    logic               wr_fire;
    logic [NUM_DOTS-1:0] dot_hits;
    logic [COLOR_W-1:0] bg_q;
    logic               unused_loc;

    assign swap       = screenEnd && !screen_end_q;
    assign id_ok      = dotID < 32'(NUM_DOTS);
    assign wr_fire    = dotWren && wr_ready;
    assign unused_loc = ^dotLoc;

`ifdef DOT_DOUBLE_BUFFER_EN
    logic [X_WIDTH-1:0] sh_x [NUM_DOTS];
    logic [Y_WIDTH-1:0] sh_y [NUM_DOTS];

    // Stalling writes during the swap cycle keeps the copy free of races.
    assign wr_ready = !swap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                sh_x[i]  <= RST_X;
                sh_y[i]  <= RST_Y;
                act_x[i] <= RST_X;
                act_y[i] <= RST_Y;
            end
        end else begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                if (wr_fire && dotID == 32'(i)) begin
                    if (is_Yloc) sh_y[i] <= dotLoc[Y_WIDTH-1:0];
                    else         sh_x[i] <= dotLoc[X_WIDTH-1:0];
                end
                if (swap) begin
                    act_x[i] <= sh_x[i];
                    act_y[i] <= sh_y[i];
                end
            end
        end
    end
`else
    assign wr_ready = 1'b1;

    // Single table: writes show up on the next pixel, tearing allowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                act_x[i] <= RST_X;
                act_y[i] <= RST_Y;
            end
        end else begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                if (wr_fire && dotID == 32'(i)) begin
                    if (is_Yloc) act_y[i] <= dotLoc[Y_WIDTH-1:0];
                    else         act_x[i] <= dotLoc[X_WIDTH-1:0];
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_DOTS; g++) begin : g_cmp
        vga_dot_cmp #(
            .X_WIDTH (X_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .DOT_SIZE(DOT_SIZE)
        ) u_cmp (
            .px    (x),
            .py    (y),
            .dot_x (act_x[g]),
            .dot_y (act_y[g]),
            .in_dot(dot_hits[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            screen_end_q <= 1'b0;
            frameTick    <= 1'b0;
            wr_err       <= 1'b0;
            hit          <= 1'b0;
            bg_q         <= '0;
        end else begin
            screen_end_q <= screenEnd;
            frameTick    <= swap;
            wr_err       <= wr_fire && !id_ok;
            if (pix_en) begin
                hit  <= |dot_hits;
                bg_q <= bgColor;
            end
        end
    end

    assign colorOut = hit ? DOT_COLOR : bg_q;
endmodule

// File: tb/tb_vga_dot_overlay.sv
// Randomized and directed bench for vga_dot_overlay; two instances (DOT_SIZE 1 and 4)
// share stimulus and are checked against a table-based reference model.
module tb_vga_dot_overlay;
    import vga_pkg::*;

    localparam int N = 20;
`ifdef DOT_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en, screenEnd, dotWren, is_Yloc;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] bgColor;
    logic [31:0] dotID, dotLoc;
    logic        wr_ready1, wr_err1, tick1, hit1;
    logic        wr_ready4, wr_err4, tick4, hit4;
    logic [11:0] color1, color4;

    vga_dot_overlay #(.NUM_DOTS(N), .DOT_SIZE(1)) u_dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .screenEnd(screenEnd),
        .x(x), .y(y), .bgColor(bgColor), .dotWren(dotWren), .is_Yloc(is_Yloc),
        .dotID(dotID), .dotLoc(dotLoc), .wr_ready(wr_ready1), .wr_err(wr_err1),
        .frameTick(tick1), .hit(hit1), .colorOut(color1)
    );

    vga_dot_overlay #(.NUM_DOTS(N), .DOT_SIZE(4)) u_dut4 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .screenEnd(screenEnd),
        .x(x), .y(y), .bgColor(bgColor), .dotWren(dotWren), .is_Yloc(is_Yloc),
        .dotID(dotID), .dotLoc(dotLoc), .wr_ready(wr_ready4), .wr_err(wr_err4),
        .frameTick(tick4), .hit(hit4), .colorOut(color4)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int          errors = 0;
    int          checks = 0;
    int          act_x[N], act_y[N], sh_x[N], sh_y[N];
    bit          se_q, exp_tick, exp_err, last_fire;
    logic [12:0] exp1, exp4;          // {hit, colorOut}
    logic [12:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int px, input int py, input int size);
        for (int i = 0; i < N; i++)
            if (px >= act_x[i] && px < act_x[i] + size && py >= act_y[i] && py < act_y[i] + size)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act_x[i] = RESET_DOT_X; act_y[i] = RESET_DOT_Y;
            sh_x[i]  = RESET_DOT_X; sh_y[i]  = RESET_DOT_Y;
        end
        se_q = 1'b0; exp_tick = 1'b0; exp_err = 1'b0;
        exp1 = '0; exp4 = '0;
        exp_q.delete();
    endtask

    task automatic check_outs();
        check("hit1", hit1, exp1[12]);
        check("color1", color1, exp1[11:0]);
        check("hit4", hit4, exp4[12]);
        check("color4", color4, exp4[11:0]);
        check("frameTick1", tick1, exp_tick);
        check("frameTick4", tick4, exp_tick);
        check("wr_err1", wr_err1, exp_err);
        check("wr_err4", wr_err4, exp_err);
    endtask

    // One clk cycle with the currently driven inputs, then compare.
    task automatic step();
        bit swap, ready, fire, h1, h4;
        int id;
        #1;
        swap  = screenEnd && !se_q;
        ready = DB ? !swap : 1'b1;
        check("wr_ready1", wr_ready1, ready);
        check("wr_ready4", wr_ready4, ready);
        fire = dotWren && ready;
        if (pix_en) begin
            h1 = model_hit(int'(x), int'(y), 1);
            h4 = model_hit(int'(x), int'(y), 4);
            exp_q.push_back({h1, h1 ? 12'h000 : bgColor});
            exp_q.push_back({h4, h4 ? 12'h000 : bgColor});
        end
        @(posedge clk);
        #1;
        exp_tick = swap;
        exp_err  = fire && (dotID >= N);
        if (fire && dotID < N) begin
            id = int'(dotID);
            if (DB) begin
                if (is_Yloc) sh_y[id] = int'(dotLoc[8:0]); else sh_x[id] = int'(dotLoc[9:0]);
            end else begin
                if (is_Yloc) act_y[id] = int'(dotLoc[8:0]); else act_x[id] = int'(dotLoc[9:0]);
            end
        end
        if (swap && DB) begin
            act_x = sh_x;
            act_y = sh_y;
        end
        se_q      = screenEnd;
        last_fire = fire;
        if (exp_q.size() >= 2) begin
            exp1 = exp_q.pop_front();
            exp4 = exp_q.pop_front();
        end
        check_outs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input int id, input bit is_y, input int loc);
        int n = 0;
        dotWren = 1'b1; is_Yloc = is_y; dotID = id; dotLoc = loc;
        do begin
            step();
            n++;
        end while (!last_fire && n < 4);
        dotWren = 1'b0;
    endtask

    task automatic scan(input int px, input int py);
        pix_en = 1'b1; x = px[9:0]; y = py[8:0]; bgColor = 12'($urandom_range(1, 4095));
        step();
        pix_en = 1'b0;
        step();
    endtask

    task automatic frame();
        screenEnd = 1'b1;
        repeat (3) step();
        screenEnd = 1'b0;
        repeat (2) step();
    endtask

    task automatic reset_mid_frame();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int xs[6] = '{636, 637, 638, 639, 0, 1};
    int ys[5] = '{477, 478, 479, 0, 1};

    initial begin
        reset = 1'b1; pix_en = 0; screenEnd = 0; dotWren = 0; is_Yloc = 0;
        x = '0; y = '0; bgColor = '0; dotID = '0; dotLoc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        check("wr_ready_rst", wr_ready1, 1'b1);
        reset = 1'b0;

        // Reset positions visible immediately.
        scan(320, 240);
        scan(321, 240);
        scan(319, 240);

        // Write dot 3, visible only after the frame swap when double-buffered.
        do_write(3, 1'b0, 100);
        do_write(3, 1'b1, 50);
        scan(100, 50);
        frame();
        scan(100, 50);

        // Write held across a screenEnd rise stalls for the swap cycle.
        screenEnd = 1'b1;
        do_write(5, 1'b0, 200);
        do_write(5, 1'b1, 60);
        scan(200, 60);
        screenEnd = 1'b0;
        step();
        frame();
        scan(200, 60);

        // Out-of-range id is flagged and changes nothing.
        do_write(25, 1'b0, 10);
        step();
        frame();
        scan(10, 240);
        scan(320, 240);

        // Dot at the bottom-right corner must not wrap.
        do_write(7, 1'b0, 638);
        do_write(7, 1'b1, 478);
        frame();
        foreach (xs[i]) scan(xs[i], 478);
        foreach (ys[i]) scan(638, ys[i]);

        // Randomized cycles.
        for (int k = 0; k < 600; k++) begin
            int id;
            id      = $urandom_range(0, N - 1);
            pix_en  = ($urandom_range(0, 2) != 0);
            x       = 10'(act_x[id] + $urandom_range(0, 5) - 1);
            y       = 9'(act_y[id] + $urandom_range(0, 5) - 1);
            bgColor = 12'($urandom);
            dotWren = ($urandom_range(0, 3) == 0);
            is_Yloc = $urandom_range(0, 1);
            dotID   = $urandom_range(0, 24);
            dotLoc  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 639);
            if ($urandom_range(0, 9) == 0) screenEnd = ~screenEnd;
            step();
        end
        dotWren = 1'b0; screenEnd = 1'b0; pix_en = 1'b0;
        step();

        // Reset while a dot is being hit.
        do_write(3, 1'b0, 100);
        do_write(3, 1'b1, 50);
        frame();
        pix_en = 1'b1; x = 10'd100; y = 9'd50; bgColor = 12'h5a5;
        step();
        pix_en = 1'b0;
        reset_mid_frame();
        step();
        scan(320, 240);
        scan(100, 50);
        frame();
        scan(320, 240);
        scan(100, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
